program_loader: RTL and testbench

- Loads a program image from the tile pins into the CPU's 16-byte RAM before execution.
- Acts as the writer side of the RAM interface that the CPU's MAR/RAM path reads.
- Holds the CPU in reset while loading, accepts one byte per external strobe, and writes each byte to sequential addresses starting at 0.
- Releases the CPU once the image is complete.

---
 rtl/program_loader.sv | 187 ++++++++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Writes a program image arriving one byte per external strobe
//               into the CPU's RAM at sequential addresses starting at 0.
//               The CPU is held in reset while the image loads.
//               Optional build macro LOADER_CHECKSUM_EN adds a trailing
//               checksum byte that is compared with the mod-256 sum of the
//               image and reported on err.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              strobe,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [7:0]        data_out,
    output logic              we_n,
    output logic              cpu_hold_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_WAIT  = 3'd1;
    localparam logic [2:0] C_ST_WRITE = 3'd2;
    localparam logic [2:0] C_ST_DONE  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] C_ST_CHECK = 3'd4;
`endif

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(RAM_BYTES - 1);
    localparam logic [ADDR_W:0]   C_FULL      = (ADDR_W + 1)'(RAM_BYTES);

    logic [2:0]        r_state;
    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic              r_pend;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_we_n;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic w_pulse;
    logic w_edge;

    // Rising edge of the synchronised strobe, plus any edge that arrived
    // while the single WRITE cycle was busy.
    assign w_pulse = r_s2 & ~r_s3;
    assign w_edge  = w_pulse | r_pend;

    // Two-flop synchroniser plus history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= strobe;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Remember an edge pulse that lands in WRITE so the following wait state
    // still services it; dropped everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= (r_state == C_ST_WRITE) ? w_pulse : 1'b0;
        end
    end

    // Load sequencer: address/data/write-enable generation and byte counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_we_n  <= 1'b1;
            r_count <= '0;
            r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_we_n <= 1'b1;
            case (r_state)
                C_ST_IDLE: begin
                    if (load_req) begin
                        r_state <= C_ST_WAIT;
                        r_addr  <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                C_ST_WAIT: begin
                    // A pending edge wins over an abort in the same cycle.
                    if (w_edge) begin
                        r_data  <= data_in;
                        r_we_n  <= 1'b0;
                        r_state <= C_ST_WRITE;
                    end else if (!load_req) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                C_ST_WRITE: begin
                    if (r_count != C_FULL) begin
                        r_count <= r_count + 1'b1;
                    end
`ifdef LOADER_CHECKSUM_EN
                    r_sum <= r_sum + r_data;
`endif
                    if (r_addr == C_LAST_ADDR) begin
                        r_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_state <= C_ST_CHECK;
`else
                        r_state <= C_ST_DONE;
`endif
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= C_ST_WAIT;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                C_ST_CHECK: begin
                    // The checksum byte is compared, never written to RAM.
                    if (w_edge) begin
                        r_err   <= (data_in != r_sum);
                        r_state <= C_ST_DONE;
                    end else if (!load_req) begin
                        r_state <= C_ST_IDLE;
                    end
                end
`endif
                C_ST_DONE: begin
                    if (!load_req) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign addr_out   = r_addr;
    assign data_out   = r_data;
    assign we_n       = r_we_n;
    assign byte_count = r_count;
`ifdef LOADER_CHECKSUM_EN
    assign err        = r_err;
    assign busy       = (r_state == C_ST_WAIT) || (r_state == C_ST_WRITE) ||
                        (r_state == C_ST_CHECK);
`else
    assign err        = 1'b0;
    assign busy       = (r_state == C_ST_WAIT) || (r_state == C_ST_WRITE);
`endif
    assign cpu_hold_n = ~busy;
    assign done       = (r_state == C_ST_DONE);

`ifndef LOADER_CHECKSUM_EN
    // err is constant in this build; keep the unused state visible to lint.
    logic w_unused;
    assign w_unused = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Randomised scoreboard bench for program_loader. A reference
//               model predicts every RAM write (address, data) and the final
//               status; a monitor compares each we_n pulse against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_req = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] addr_out;
    logic [7:0] data_out;
    logic       we_n;
    logic       cpu_hold_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] byte_count;

    program_loader #(.RAM_BYTES(N), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .strobe(strobe),
        .data_in(data_in), .addr_out(addr_out), .data_out(data_out),
        .we_n(we_n), .cpu_hold_n(cpu_hold_n), .busy(busy), .done(done),
        .err(err), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] sb_q[$];
    logic [11:0] mon_e;
    logic        prev_we = 1'b1;

    // Reference model: a load in progress accepts bytes into consecutive
    // addresses until the RAM is full; the running sum feeds the checksum.
    bit          mdl_active = 0;
    int          mdl_count = 0;
    logic [7:0]  mdl_sum = 8'h00;
    bit          mdl_chk = 0;
    bit          mdl_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next expected write and last
    // exactly one cycle.
    always @(negedge clk) begin
        if (rst_n && we_n === 1'b0) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr_out, data_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("write_addr", 32'(addr_out), 32'(mon_e[11:8]));
                check("write_data", 32'(data_out), 32'(mon_e[7:0]));
            end
            check("we_n_single_cycle", 32'(prev_we), 32'd1);
        end
        prev_we = we_n;
    end

    task automatic send_byte(input logic [7:0] b);
        bit exp_wr;
        exp_wr = mdl_active && (mdl_count < N);
        @(negedge clk);
        data_in = b;
        strobe  = 1'b1;
        if (exp_wr) begin
            sb_q.push_back({4'(mdl_count), b});
            mdl_count++;
            mdl_sum += b;
        end
`ifdef LOADER_CHECKSUM_EN
        else if (mdl_active && !mdl_chk) begin
            mdl_chk = 1;
            mdl_err = (b != mdl_sum);
        end
`endif
        repeat (2) @(negedge clk);
        if (exp_wr) check("we_n_early", 32'(we_n), 32'd1);
        @(negedge clk);
        if (exp_wr) check("we_n_latency", 32'(we_n), 32'd0);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic start_load();
        @(negedge clk);
        load_req   = 1'b1;
        mdl_active = 1;
        mdl_count  = 0;
        mdl_sum    = 8'h00;
        mdl_chk    = 0;
        mdl_err    = 0;
        @(negedge clk);
        check("start_count", 32'(byte_count), 32'd0);
        check("start_addr", 32'(addr_out), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold_n", 32'(cpu_hold_n), 32'd0);
    endtask

    task automatic stop_load();
        @(negedge clk);
        load_req   = 1'b0;
        mdl_active = 0;
        @(negedge clk);
        check("stop_done", 32'(done), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_hold_n", 32'(cpu_hold_n), 32'd1);
    endtask

    task automatic check_complete();
        @(negedge clk);
        check("end_done", 32'(done), 32'd1);
        check("end_count", 32'(byte_count), 32'(mdl_count));
        check("end_hold_n", 32'(cpu_hold_n), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_err", 32'(err), 32'(mdl_err));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"}, 32'(addr_out), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_we_n"}, 32'(we_n), 32'd1);
        check({tag, "_hold_n"}, 32'(cpu_hold_n), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_count"}, 32'(byte_count), 32'd0);
    endtask

    task automatic full_load(input bit use_ramp, input bit good_sum);
        for (int i = 0; i < N; i++) begin
            send_byte(use_ramp ? 8'(8'h10 + i) : 8'($urandom_range(0, 255)));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(good_sum ? mdl_sum : 8'(mdl_sum + 8'($urandom_range(1, 255))));
`else
        if (good_sum) mdl_err = 0;
`endif
        check_complete();
    endtask

    initial begin
        int abort_n;
        logic [7:0] b;

        // Power-on reset, then an asynchronous reset in mid-cycle.
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Strobes while idle must never write.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));

        // Full load with the ramp image, then strobes in DONE are ignored.
        start_load();
        full_load(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) send_byte(8'($urandom_range(0, 255)));
        check("done_hold_count", 32'(byte_count), 32'd16);
        stop_load();

        // Abort after a random number of bytes, then a fresh random load.
        abort_n = int'($urandom_range(1, 15));
        start_load();
        for (int i = 0; i < abort_n; i++) send_byte(8'($urandom_range(0, 255)));
        check("abort_pre_busy", 32'(busy), 32'd1);
        check("abort_pre_count", 32'(byte_count), 32'(abort_n));
        stop_load();
        check("abort_count", 32'(byte_count), 32'(abort_n));
        start_load();
        full_load(1'b0, ($urandom_range(0, 1) == 1));
        stop_load();

        // Asynchronous reset landing inside the write cycle.
        start_load();
        send_byte(8'($urandom_range(0, 255)));
        send_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        b = 8'($urandom_range(1, 255));
        data_in = b;
        strobe  = 1'b1;
        sb_q.push_back({4'(mdl_count), b});
        for (int i = 0; i < 10 && we_n !== 1'b0; i++) @(negedge clk);
        check("rst_wr_we_seen", 32'(we_n), 32'd0);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("rst_in_write");
        mdl_active = 0;
        load_req   = 1'b0;
        strobe     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_load();
        send_byte(8'($urandom_range(0, 255)));
        check("post_rst_count", 32'(byte_count), 32'd1);
        stop_load();

`ifdef LOADER_CHECKSUM_EN
        // Known image of 0x01 bytes: sum 0x10 matches, 0x11 does not.
        for (int k = 0; k < 2; k++) begin
            start_load();
            for (int i = 0; i < N; i++) send_byte(8'h01);
            send_byte(k == 0 ? 8'h10 : 8'h11);
            check_complete();
            check("chk_err_fixed", 32'(err), 32'(k));
            stop_load();
        end
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
